// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: one-at-a-time RV32M multiply/divide sequencer.
// Multiplies finish after a fixed latency. Divides use a restoring radix-2
// loop on operand magnitudes followed by a sign fix-up cycle. Divide by zero
// and signed overflow bypass the loop and respond on the next cycle.
module muldiv_sequencer #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_tag,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_tag,
  input  logic        flush,
  output logic        busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]  state;
  logic [2:0]  op_q;
  logic [31:0] opa_q;      // mul: rs1; div: quotient/dividend shift register
  logic [31:0] opb_q;      // mul: rs2; div: divisor magnitude
  logic [31:0] rem_q;
  logic [5:0]  cnt;
  logic [2:0]  mul_cnt;
  logic        neg_q;
  logic        neg_r;

  // op 0 low word; op 1 signed x signed; op 2 signed x unsigned; op 3 unsigned x unsigned
  function automatic logic [31:0] mul_calc(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = (op == 3'd3) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = op[1] ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (op[1:0] == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Request-side decode of the divide special cases and operand magnitudes
  logic        div_signed;
  logic        div_rem;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] rs1_mag;
  logic [31:0] rs2_mag;
  logic [31:0] mul_now;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    div_signed = ~req_op[0];
    div_rem    = req_op[1];
    div_zero   = (req_rs2 == 32'd0);
    div_ovf    = div_signed && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
    rs1_mag    = (div_signed && req_rs1[31]) ? -req_rs1 : req_rs1;
    rs2_mag    = (div_signed && req_rs2[31]) ? -req_rs2 : req_rs2;
    mul_now    = mul_calc(req_op, req_rs1, req_rs2);
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] fix_result;

  always_comb begin
    shifted    = {rem_q, opa_q[31]};
    trial      = shifted - {1'b0, opb_q};
    fix_result = op_q[1] ? (neg_r ? -rem_q : rem_q)
                         : (neg_q ? -opa_q : opa_q);
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Sequencer state, datapath and registered response
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control and visible outputs are reset; operand/datapath registers are always loaded before use.
      state       <= S_IDLE;
      resp_valid  <= 1'b0;
      resp_result <= 32'd0;
      resp_tag    <= 5'd0;
      cnt         <= 6'd0;
    end else if (flush) begin
      state      <= S_IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            resp_tag <= req_tag;
            if (!req_op[2]) begin
              opa_q   <= req_rs1;
              opb_q   <= req_rs2;
              mul_cnt <= 3'(MUL_LATENCY - 2);
              if (MUL_LATENCY == 1) begin
                resp_result <= mul_now;
                resp_valid  <= 1'b1;
                state       <= S_RESP;
              end else begin
                state <= S_MUL;
              end
            end else if (div_zero) begin
              resp_result <= div_rem ? req_rs1 : 32'hFFFF_FFFF;
              resp_valid  <= 1'b1;
              state       <= S_RESP;
            end else if (div_ovf) begin
              resp_result <= div_rem ? 32'd0 : 32'h8000_0000;
              resp_valid  <= 1'b1;
              state       <= S_RESP;
            end else begin
              opa_q <= rs1_mag;
              opb_q <= rs2_mag;
              rem_q <= 32'd0;
              neg_q <= div_signed && (req_rs1[31] ^ req_rs2[31]);
              neg_r <= div_signed && req_rs1[31];
              cnt   <= 6'd31;
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (mul_cnt == 3'd0) begin
            resp_result <= mul_calc(op_q, opa_q, opb_q);
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end else begin
            mul_cnt <= mul_cnt - 3'd1;
          end
        end
        S_DIV: begin
          rem_q <= trial[32] ? shifted[31:0] : trial[31:0];
          opa_q <= {opa_q[30:0], ~trial[32]};
          if (cnt == 6'd0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        S_FIX: begin
          resp_result <= fix_result;
          resp_valid  <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
